control_unit: RTL and testbench



---
 rtl/control_unit.sv | 77 +++++++
 tb/tb_control_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder with run-control FSM (start, halt, illegal-opcode trap)
package control_unit_pkg;
  typedef enum logic [2:0] {SEL_REG = 3'd0, SEL_IMM = 3'd1, SEL_PC = 3'd2, SEL_ZERO = 3'd3, SEL_FOUR = 3'd4} alu_sel_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_BRANCH = 2'd1, ALU_RTYPE = 2'd2, ALU_ITYPE = 2'd3} aluOp_t;
  typedef enum logic [6:0] {
    LTYPE = 7'b0000011, ITYPE = 7'b0010011, AUIPC = 7'b0010111, STYPE = 7'b0100011,
    RTYPE = 7'b0110011, LUI   = 7'b0110111, BTYPE = 7'b1100011, JALR  = 7'b1100111,
    JTYPE = 7'b1101111, HALT  = 7'b1111111
  } opCode_t;
endpackage

module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opCode,
  input  logic       enable,
  input  logic       startProcess,
  output logic       endProcess,
  output logic       error,
  output logic       jump,
  output logic       jumpReg,
  output logic       branch,
  output logic       memRead,
  output logic       memWrite,
  output logic       memtoReg,
  output logic       regWrite,
  output alu_sel_t   aluSrc1,
  output alu_sel_t   aluSrc2,
  output aluOp_t     aluOp
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
  state_t state;
  logic active, known;
  assign active = state == RUN && enable;
  always_comb begin
    known = 1'b1;
    {jump, jumpReg, branch, memRead, memWrite, memtoReg, regWrite} = '0;
    aluSrc1 = SEL_REG;
    aluSrc2 = SEL_REG;
    aluOp = ALU_ADD;
    case (opCode)
      LTYPE: begin {memRead, memtoReg, regWrite} = '1; aluSrc2 = SEL_IMM; end
      ITYPE: begin regWrite = 1'b1; aluSrc2 = SEL_IMM; aluOp = ALU_ITYPE; end
      AUIPC: begin regWrite = 1'b1; aluSrc1 = SEL_PC; aluSrc2 = SEL_IMM; end
      STYPE: begin memWrite = 1'b1; aluSrc2 = SEL_IMM; end
      RTYPE: begin regWrite = 1'b1; aluOp = ALU_RTYPE; end
      LUI:   begin regWrite = 1'b1; aluSrc1 = SEL_ZERO; aluSrc2 = SEL_IMM; end
      BTYPE: begin branch = 1'b1; aluOp = ALU_BRANCH; end
      JALR:  begin {jump, jumpReg, regWrite} = '1; aluSrc1 = SEL_PC; aluSrc2 = SEL_FOUR; end
      JTYPE: begin {jump, regWrite} = '1; aluSrc1 = SEL_PC; aluSrc2 = SEL_FOUR; end
      default: known = 1'b0;
    endcase
    // halt and illegal opcodes fall into default, so they also decode to idle strobes
    if (!active) begin
      {jump, jumpReg, branch, memRead, memWrite, memtoReg, regWrite} = '0;
      aluSrc1 = SEL_REG;
      aluSrc2 = SEL_REG;
      aluOp = ALU_ADD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      endProcess <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (startProcess) begin state <= RUN; endProcess <= 1'b0; end
        RUN: if (enable && opCode == HALT) begin state <= DONE; endProcess <= 1'b1; end
             else if (enable && !known) begin state <= ERR; error <= 1'b1; end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of decode table and run-control FSM
module tb_control_unit;
  import control_unit_pkg::*;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, startProcess = 1'b0;
  logic [6:0] opCode = 7'd0;
  logic endProcess, error, jump, jumpReg, branch, memRead, memWrite, memtoReg, regWrite;
  alu_sel_t aluSrc1, aluSrc2;
  aluOp_t aluOp;
  int total = 0, bad = 0;
  logic [14:0] outv;
  assign outv = {jump, jumpReg, branch, memRead, memWrite, memtoReg, regWrite, aluSrc1, aluSrc2, aluOp};
  control_unit dut (
    .clk(clk), .rst(rst), .opCode(opCode), .enable(enable), .startProcess(startProcess),
    .endProcess(endProcess), .error(error), .jump(jump), .jumpReg(jumpReg), .branch(branch),
    .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg), .regWrite(regWrite),
    .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .aluOp(aluOp)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // strobes ordered jump,jumpReg,branch,memRead,memWrite,memtoReg,regWrite
  function automatic logic [14:0] v(input logic [6:0] s, input logic [2:0] a, input logic [2:0] b, input logic [1:0] o);
    return {s, a, b, o};
  endfunction
  task automatic dec(input string tag, input logic [6:0] op, input logic [14:0] exp);
    opCode = op;
    #2;
    chk(tag, outv, exp);
  endtask
  initial begin
    tick();
    tick();
    chk("reset_out", outv, 15'd0);
    chk("reset_end", {14'd0, endProcess}, 15'd0);
    chk("reset_err", {14'd0, error}, 15'd0);
    rst = 1'b0;
    dec("idle_nodec", 7'b0110011, 15'd0);
    startProcess = 1'b1;
    opCode = 7'b1100011;
    tick();
    startProcess = 1'b0;
    dec("run_en0", 7'b1100011, 15'd0);
    enable = 1'b1;
    dec("btype", 7'b1100011, v(7'b0010000, 3'd0, 3'd0, 2'd1));
    dec("jtype", 7'b1101111, v(7'b1000001, 3'd2, 3'd4, 2'd0));
    dec("itype", 7'b0010011, v(7'b0000001, 3'd0, 3'd1, 2'd3));
    dec("auipc", 7'b0010111, v(7'b0000001, 3'd2, 3'd1, 2'd0));
    dec("ltype", 7'b0000011, v(7'b0001011, 3'd0, 3'd1, 2'd0));
    dec("stype", 7'b0100011, v(7'b0000100, 3'd0, 3'd1, 2'd0));
    dec("rtype", 7'b0110011, v(7'b0000001, 3'd0, 3'd0, 2'd2));
    dec("lui", 7'b0110111, v(7'b0000001, 3'd3, 3'd1, 2'd0));
    dec("jalr", 7'b1100111, v(7'b1100001, 3'd2, 3'd4, 2'd0));
    tick();
    enable = 1'b0;
    opCode = 7'b1111111;
    tick();
    chk("halt_en0_end", {14'd0, endProcess}, 15'd0);
    enable = 1'b1;
    dec("still_run", 7'b0110011, v(7'b0000001, 3'd0, 3'd0, 2'd2));
    tick();
    dec("halt_strobes", 7'b1111111, 15'd0);
    chk("halt_end_same", {14'd0, endProcess}, 15'd0);
    tick();
    chk("halt_end", {14'd0, endProcess}, 15'd1);
    dec("done_nodec", 7'b1100011, 15'd0);
    tick();
    chk("done_hold", {14'd0, endProcess}, 15'd1);
    startProcess = 1'b1;
    tick();
    startProcess = 1'b0;
    chk("restart_end", {14'd0, endProcess}, 15'd0);
    dec("restart_dec", 7'b0100011, v(7'b0000100, 3'd0, 3'd1, 2'd0));
    tick();
    dec("illegal_strobes", 7'b0000000, 15'd0);
    chk("illegal_err_same", {14'd0, error}, 15'd0);
    tick();
    chk("illegal_err", {14'd0, error}, 15'd1);
    startProcess = 1'b1;
    tick();
    startProcess = 1'b0;
    chk("err_sticky", {14'd0, error}, 15'd1);
    dec("err_nodec", 7'b0110011, 15'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", {14'd0, error}, 15'd0);
    dec("post_rst_idle", 7'b0110011, 15'd0);
    startProcess = 1'b1;
    tick();
    startProcess = 1'b0;
    dec("mid_stype", 7'b0100011, v(7'b0000100, 3'd0, 3'd1, 2'd0));
    rst = 1'b1;
    tick();
    chk("rst_mid_run", outv, 15'd0);
    rst = 1'b0;
    tick();
    chk("rst_stays_idle", outv, 15'd0);
    rst = 1'b1;
    startProcess = 1'b1;
    tick();
    rst = 1'b0;
    startProcess = 1'b0;
    tick();
    chk("rst_beats_start", outv, 15'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
